// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the core's fetch/data ports, mem_bus_arbiter and the external memory bus.
// The arbiter uses the master modport; the requesters and the bus slave together use slave.
interface mem_bus_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    // Fetch port
    logic              if_ce_i;
    logic [DATA_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_stallreq_o;

    // Data port
    logic              mem_ce_i;
    logic              mem_we_i;
    logic [3:0]        mem_sel_i;
    logic [DATA_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_stallreq_o;

    // External memory bus
    logic              bus_req_o;
    logic              bus_we_o;
    logic [3:0]        bus_sel_o;
    logic [DATA_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_data_o;
    logic [DATA_W-1:0] bus_data_i;
    logic              bus_ack_i;
    logic              bus_err_o;

    modport master (
        input  if_ce_i, if_addr_i,
        output if_data_o, if_stallreq_o,
        input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
        output mem_data_o, mem_stallreq_o,
        output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, bus_err_o,
        input  bus_data_i, bus_ack_i
    );

    modport slave (
        output if_ce_i, if_addr_i,
        input  if_data_o, if_stallreq_o,
        output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
        input  mem_data_o, mem_stallreq_o,
        input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, bus_err_o,
        output bus_data_i, bus_ack_i
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one request/acknowledge memory bus between the fetch and data ports.
// Data port has fixed priority; each bus cycle is bounded by a timeout.
module mem_bus_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    mem_bus_arbiter_if.master bus
);

    localparam int unsigned SEL_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0] SEL_ALL  = {SEL_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_MEM = 2'd1,
        BUS_IF  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              if_served_q, if_served_d;
    logic              mem_served_q, mem_served_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;

    logic mem_pending;
    logic if_pending;
    logic cycle_done;
    logic tmo_hit;

    // Only the IF/ID and MEM/WB stall bits release the served flags.
    logic unused_stall;
    assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

    always_comb begin
        mem_pending = bus.mem_ce_i && !mem_served_q;
        if_pending  = bus.if_ce_i && !if_served_q;
        tmo_hit     = (cnt_q == CNT_LAST);
        cycle_done  = bus.bus_ack_i || tmo_hit;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_pending) begin
                    state_d = BUS_MEM;
                end else if (if_pending) begin
                    state_d = BUS_IF;
                end
            end
            BUS_MEM, BUS_IF: begin
                if (cycle_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; served set wins over the stall-driven clear
    always_comb begin
        cnt_d        = cnt_q;
        if_served_d  = if_served_q && stall_i[1];
        mem_served_d = mem_served_q && stall_i[4];
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_sel_d    = bus_sel_q;
        bus_addr_d   = bus_addr_q;
        bus_data_d   = bus_data_q;
        bus_err_d    = 1'b0;
        if_data_d    = if_data_q;
        mem_data_d   = mem_data_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_pending) begin
                    bus_req_d  = 1'b1;
                    bus_we_d   = bus.mem_we_i;
                    bus_sel_d  = bus.mem_sel_i;
                    bus_addr_d = bus.mem_addr_i;
                    bus_data_d = bus.mem_data_i;
                end else if (if_pending) begin
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = SEL_ALL;
                    bus_addr_d = bus.if_addr_i;
                end
            end
            BUS_MEM: begin
                if (cycle_done) begin
                    bus_req_d    = 1'b0;
                    bus_we_d     = 1'b0;
                    cnt_d        = '0;
                    mem_served_d = 1'b1;
                    if (bus.bus_ack_i) begin
                        if (!bus_we_q) begin
                            mem_data_d = bus.bus_data_i;
                        end
                    end else begin
                        bus_err_d = 1'b1;
                        if (!bus_we_q) begin
                            mem_data_d = '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BUS_IF: begin
                if (cycle_done) begin
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    cnt_d       = '0;
                    if_served_d = 1'b1;
                    if (bus.bus_ack_i) begin
                        if_data_d = bus.bus_data_i;
                    end else begin
                        bus_err_d = 1'b1;
                        if_data_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                bus_req_d = 1'b0;
                bus_we_d  = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    // Datapath registers; reset abandons any cycle in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            if_served_q  <= 1'b0;
            mem_served_q <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_sel_q    <= '0;
            bus_addr_q   <= '0;
            bus_data_q   <= '0;
            bus_err_q    <= 1'b0;
            if_data_q    <= '0;
            mem_data_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            if_served_q  <= if_served_d;
            mem_served_q <= mem_served_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_sel_q    <= bus_sel_d;
            bus_addr_q   <= bus_addr_d;
            bus_data_q   <= bus_data_d;
            bus_err_q    <= bus_err_d;
            if_data_q    <= if_data_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign bus.if_stallreq_o  = if_pending;
    assign bus.mem_stallreq_o = mem_pending;
    assign bus.if_data_o      = if_data_q;
    assign bus.mem_data_o     = mem_data_q;
    assign bus.bus_req_o      = bus_req_q;
    assign bus.bus_we_o       = bus_we_q;
    assign bus.bus_sel_o      = bus_sel_q;
    assign bus.bus_addr_o     = bus_addr_q;
    assign bus.bus_data_o     = bus_data_q;
    assign bus.bus_err_o      = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table plus hand-written corner sequences,
// with a scoreboard of expected bus cycles checked by a bus monitor.
module tb_mem_bus_arbiter;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 8;

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;       // edge index of ack after issue; 0 = never ack
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] data;
    } bus_rec_t;

    logic       clk;
    logic       rst;
    logic [5:0] stall_i;

    int errors;
    int checks;

    bus_rec_t exp_q[$];
    bus_rec_t cur;
    logic     have_cur;
    logic     req_prev;

    vec_t vecs[9];

    mem_bus_arbiter_if #(.DATA_W(DATA_W)) bif ();

    mem_bus_arbiter #(
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .stall_i(stall_i),
        .bus    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic is_mem, input logic we, input logic [3:0] sel,
                                input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                                input logic [31:0] rdata, input logic [31:0] exp_data,
                                input logic exp_err);
        vec_t v;
        v.is_mem = is_mem; v.we = we; v.sel = sel; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.rdata = rdata; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    // Bus monitor: each new bus cycle must match the oldest expected cycle and stay stable
    always @(negedge clk) begin
        if (bif.bus_req_o) begin
            if (!req_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bus_cycle", 32'(bif.bus_req_o), 32'd0);
                    have_cur = 1'b0;
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (have_cur) begin
                check("bus_addr", bif.bus_addr_o, cur.addr);
                check("bus_we", 32'(bif.bus_we_o), 32'(cur.we));
                check("bus_sel", 32'(bif.bus_sel_o), 32'(cur.sel));
                if (cur.we) begin
                    check("bus_wdata", bif.bus_data_o, cur.data);
                end
            end
        end
        req_prev = bif.bus_req_o;
    end

    // Applies one table vector starting at a negedge with both ports idle
    task automatic run_txn(input int idx, input vec_t v);
        bus_rec_t r;
        int       n_cyc;
        logic     sreq;
        r.addr = v.addr;
        r.we   = v.is_mem ? v.we : 1'b0;
        r.sel  = v.is_mem ? v.sel : 4'hF;
        r.data = v.wdata;
        exp_q.push_back(r);
        if (v.is_mem) begin
            bif.mem_ce_i   = 1'b1;
            bif.mem_we_i   = v.we;
            bif.mem_sel_i  = v.sel;
            bif.mem_addr_i = v.addr;
            bif.mem_data_i = v.wdata;
        end else begin
            bif.if_ce_i   = 1'b1;
            bif.if_addr_i = v.addr;
        end
        #1;
        sreq = v.is_mem ? bif.mem_stallreq_o : bif.if_stallreq_o;
        check($sformatf("v%0d_stall_pre", idx), 32'(sreq), 32'd1);
        @(negedge clk);
        n_cyc = (v.lat == 0) ? int'(TIMEOUT) : v.lat;
        for (int i = 1; i <= n_cyc; i++) begin
            sreq = v.is_mem ? bif.mem_stallreq_o : bif.if_stallreq_o;
            check($sformatf("v%0d_req_c%0d", idx, i), 32'(bif.bus_req_o), 32'd1);
            check($sformatf("v%0d_stall_c%0d", idx, i), 32'(sreq), 32'd1);
            if (i == v.lat) begin
                bif.bus_ack_i  = 1'b1;
                bif.bus_data_i = (v.is_mem && v.we) ? (32'hBAD0_0000 | 32'(idx)) : v.rdata;
            end
            @(negedge clk);
            bif.bus_ack_i  = 1'b0;
            bif.bus_data_i = $urandom();
        end
        sreq = v.is_mem ? bif.mem_stallreq_o : bif.if_stallreq_o;
        check($sformatf("v%0d_req_done", idx), 32'(bif.bus_req_o), 32'd0);
        check($sformatf("v%0d_stall_done", idx), 32'(sreq), 32'd0);
        check($sformatf("v%0d_err", idx), 32'(bif.bus_err_o), 32'(v.exp_err));
        check($sformatf("v%0d_data", idx), v.is_mem ? bif.mem_data_o : bif.if_data_o, v.exp_data);
        bif.mem_ce_i = 1'b0;
        bif.if_ce_i  = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_err_clear", idx), 32'(bif.bus_err_o), 32'd0);
        check($sformatf("v%0d_no_reissue", idx), 32'(bif.bus_req_o), 32'd0);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        have_cur = 1'b0;
        req_prev = 1'b0;
        rst      = 1'b1;
        stall_i  = 6'b0;
        bif.if_ce_i    = 1'b0;
        bif.if_addr_i  = '0;
        bif.mem_ce_i   = 1'b0;
        bif.mem_we_i   = 1'b0;
        bif.mem_sel_i  = 4'h0;
        bif.mem_addr_i = '0;
        bif.mem_data_i = '0;
        bif.bus_data_i = '0;
        bif.bus_ack_i  = 1'b0;

        //              mem  we   sel      addr          wdata         lat rdata         exp_data      err
        vecs[0] = mk(1'b0, 1'b0, 4'hF,    32'h0000_0010, 32'h0,        2, 32'h0050_0093, 32'h0050_0093, 1'b0);
        vecs[1] = mk(1'b1, 1'b1, 4'b0011, 32'h0000_0040, 32'hDEAD_BEEF, 3, 32'h0,        32'h0000_0000, 1'b0);
        vecs[2] = mk(1'b1, 1'b0, 4'hF,    32'h0000_0044, 32'h0,        1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
        vecs[3] = mk(1'b1, 1'b1, 4'b1100, 32'h0000_0048, 32'h1122_3344, 8, 32'h0,        32'hCAFE_F00D, 1'b0);
        vecs[4] = mk(1'b1, 1'b0, 4'hF,    32'h0000_004C, 32'h0,        0, 32'h0,        32'h0000_0000, 1'b1);
        vecs[5] = mk(1'b0, 1'b0, 4'hF,    32'h0000_0020, 32'h0,        1, 32'h0000_0013, 32'h0000_0013, 1'b0);
        vecs[6] = mk(1'b0, 1'b0, 4'hF,    32'h0000_0024, 32'h0,        0, 32'h0,        32'h0000_0000, 1'b1);
        vecs[7] = mk(1'b1, 1'b0, 4'hF,    32'h0000_0050, 32'h0,        4, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0);
        vecs[8] = mk(1'b1, 1'b1, 4'b1000, 32'h0000_0054, 32'h0000_0099, 0, 32'h0,        32'hA5A5_5A5A, 1'b1);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bus_req", 32'(bif.bus_req_o), 32'd0);
        check("rst_bus_we", 32'(bif.bus_we_o), 32'd0);
        check("rst_bus_sel", 32'(bif.bus_sel_o), 32'd0);
        check("rst_bus_addr", bif.bus_addr_o, 32'd0);
        check("rst_bus_data", bif.bus_data_o, 32'd0);
        check("rst_bus_err", 32'(bif.bus_err_o), 32'd0);
        check("rst_if_data", bif.if_data_o, 32'd0);
        check("rst_mem_data", bif.mem_data_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_txn(i, vecs[i]);
        end

        // Simultaneous requests: MEM first, one IDLE cycle, then IF
        stall_i        = 6'b010010;
        bif.mem_ce_i   = 1'b1;
        bif.mem_we_i   = 1'b0;
        bif.mem_sel_i  = 4'hF;
        bif.mem_addr_i = 32'h0000_0100;
        bif.if_ce_i    = 1'b1;
        bif.if_addr_i  = 32'h0000_0000;
        exp_q.push_back('{addr: 32'h100, we: 1'b0, sel: 4'hF, data: 32'h0});
        exp_q.push_back('{addr: 32'h000, we: 1'b0, sel: 4'hF, data: 32'h0});
        #1;
        check("pri_if_stall_pre", 32'(bif.if_stallreq_o), 32'd1);
        check("pri_mem_stall_pre", 32'(bif.mem_stallreq_o), 32'd1);
        @(negedge clk);
        check("pri_first_addr", bif.bus_addr_o, 32'h0000_0100);
        bif.bus_ack_i  = 1'b1;
        bif.bus_data_i = 32'h0000_0AAA;
        @(negedge clk);
        bif.bus_ack_i  = 1'b0;
        check("pri_idle_gap", 32'(bif.bus_req_o), 32'd0);
        check("pri_mem_stall_lo", 32'(bif.mem_stallreq_o), 32'd0);
        check("pri_if_stall_hold", 32'(bif.if_stallreq_o), 32'd1);
        check("pri_mem_data", bif.mem_data_o, 32'h0000_0AAA);
        @(negedge clk);
        check("pri_second_req", 32'(bif.bus_req_o), 32'd1);
        check("pri_second_addr", bif.bus_addr_o, 32'h0000_0000);
        check("pri_if_stall_c2", 32'(bif.if_stallreq_o), 32'd1);
        bif.bus_ack_i  = 1'b1;
        bif.bus_data_i = 32'h0000_0BBB;
        @(negedge clk);
        bif.bus_ack_i  = 1'b0;
        check("pri_if_stall_lo", 32'(bif.if_stallreq_o), 32'd0);
        check("pri_if_data", bif.if_data_o, 32'h0000_0BBB);
        check("pri_mem_data_keep", bif.mem_data_o, 32'h0000_0AAA);
        stall_i      = 6'b0;
        bif.mem_ce_i = 1'b0;
        bif.if_ce_i  = 1'b0;
        @(negedge clk);
        check("pri_quiet", 32'(bif.bus_req_o), 32'd0);

        // Served flag holds the MEM port while MEM/WB is stalled
        stall_i        = 6'b010000;
        bif.mem_ce_i   = 1'b1;
        bif.mem_we_i   = 1'b0;
        bif.mem_sel_i  = 4'hF;
        bif.mem_addr_i = 32'h0000_0080;
        exp_q.push_back('{addr: 32'h80, we: 1'b0, sel: 4'hF, data: 32'h0});
        @(negedge clk);
        bif.bus_ack_i  = 1'b1;
        bif.bus_data_i = 32'h1357_9BDF;
        @(negedge clk);
        bif.bus_ack_i  = 1'b0;
        bif.bus_data_i = 32'hFFFF_0000;
        check("srv_mem_data", bif.mem_data_o, 32'h1357_9BDF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("srv_no_req_%0d", i), 32'(bif.bus_req_o), 32'd0);
            check($sformatf("srv_stall_lo_%0d", i), 32'(bif.mem_stallreq_o), 32'd0);
            check($sformatf("srv_data_%0d", i), bif.mem_data_o, 32'h1357_9BDF);
        end
        stall_i = 6'b0;
        @(negedge clk);
        check("srv_cleared", 32'(bif.mem_stallreq_o), 32'd1);
        check("srv_clear_no_req", 32'(bif.bus_req_o), 32'd0);
        bif.mem_ce_i = 1'b0;
        @(negedge clk);
        check("srv_final_no_req", 32'(bif.bus_req_o), 32'd0);

        // Reset in the middle of a fetch cycle; the late ack must be ignored
        stall_i       = 6'b000010;
        bif.if_ce_i   = 1'b1;
        bif.if_addr_i = 32'h0000_0030;
        exp_q.push_back('{addr: 32'h30, we: 1'b0, sel: 4'hF, data: 32'h0});
        @(negedge clk);
        check("mrst_req_hi", 32'(bif.bus_req_o), 32'd1);
        rst         = 1'b1;
        bif.if_ce_i = 1'b0;
        stall_i     = 6'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_req_lo", 32'(bif.bus_req_o), 32'd0);
        check("mrst_addr", bif.bus_addr_o, 32'd0);
        check("mrst_sel", 32'(bif.bus_sel_o), 32'd0);
        check("mrst_mem_data", bif.mem_data_o, 32'd0);
        check("mrst_if_data", bif.if_data_o, 32'd0);
        bif.bus_ack_i  = 1'b1;
        bif.bus_data_i = 32'hFFFF_FFFF;
        @(negedge clk);
        bif.bus_ack_i = 1'b0;
        check("mrst_ack_ignored", bif.if_data_o, 32'd0);
        check("mrst_still_idle", 32'(bif.bus_req_o), 32'd0);
        check("mrst_no_err", 32'(bif.bus_err_o), 32'd0);
        run_txn(9, mk(1'b0, 1'b0, 4'hF, 32'h0000_0034, 32'h0, 1, 32'h00A0_0113, 32'h00A0_0113, 1'b0));

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
